// File: rtl/hamming_secded_codec.sv
// Parametrised Hamming SECDED codec: independent encode (1 stage) and decode (2 stage)
// valid/ready pipelines plus saturating corrected/uncorrectable error counters.

package hamming_secded_pkg;

  // Smallest P with 2**P >= data_w + P + 1.
  function automatic int calc_par_w(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

endpackage

module hamming_secded_codec
  import hamming_secded_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  CNT_W  = 16,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_i_valid,
  output logic              enc_i_ready,
  input  logic [DATA_W-1:0] enc_i_data,
  output logic              enc_o_valid,
  input  logic              enc_o_ready,
  output logic [CODE_W-1:0] enc_o_code,
  input  logic              dec_i_valid,
  output logic              dec_i_ready,
  input  logic [CODE_W-1:0] dec_i_code,
  output logic              dec_o_valid,
  input  logic              dec_o_ready,
  output logic [DATA_W-1:0] dec_o_data,
  output logic              dec_o_single,
  output logic              dec_o_double,
  output logic [PAR_W:0]    dec_o_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);

  // Codeword bit i is Hamming position i; powers of two carry parity, bit 0 is overall parity.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] code;
    int                j;
    code = '0;
    j    = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        code[i] = data[j];
        j++;
      end
    end
    for (int k = 0; k < PAR_W; k++) begin
      for (int i = 1; i < CODE_W; i++) begin
        if (i[k] && (i != (1 << k))) code[1 << k] = code[1 << k] ^ code[i];
      end
    end
    code[0] = ^code[CODE_W-1:1];
    return code;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] data;
    int                j;
    data = '0;
    j    = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        data[j] = code[i];
        j++;
      end
    end
    return data;
  endfunction

  function automatic logic [PAR_W-1:0] syndrome(input logic [CODE_W-1:0] code);
    logic [PAR_W-1:0] syn;
    syn = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (code[i]) syn = syn ^ i[PAR_W-1:0];
    end
    return syn;
  endfunction

  // ---------------------------------------------------------------- encoder
  assign enc_i_ready = !enc_o_valid || enc_o_ready;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_o_valid <= 1'b0;
      enc_o_code  <= '0;
    end else if (enc_i_ready) begin
      enc_o_valid <= enc_i_valid;
      if (enc_i_valid) enc_o_code <= encode(enc_i_data);
    end
  end

  // ---------------------------------------------------------------- decoder
  logic              s1_valid;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_ovp;
  logic [CODE_W-1:0] s1_code;
  logic              s1_ready;
  logic              s2_ready;

  assign s2_ready    = !dec_o_valid || dec_o_ready;
  assign s1_ready    = !s1_valid || s2_ready;
  assign dec_i_ready = s1_ready;

  // NOTE: payload registers are reset as well, so data, flags and pos read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_syn   <= '0;
      s1_ovp   <= 1'b0;
      s1_code  <= '0;
    end else if (s1_ready) begin
      s1_valid <= dec_i_valid;
      if (dec_i_valid) begin
        s1_syn  <= syndrome(dec_i_code);
        s1_ovp  <= ^dec_i_code;
        s1_code <= dec_i_code;
      end
    end
  end

  logic              fix_single;
  logic              fix_double;
  logic [CODE_W-1:0] fix_code;
  logic [PAR_W:0]    fix_pos;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    fix_single = 1'b0;
    fix_double = 1'b0;
    if (s1_ovp) begin
      if (int'(s1_syn) < CODE_W) fix_single = 1'b1;
      else                       fix_double = 1'b1;
    end else if (s1_syn != '0) begin
      fix_double = 1'b1;
    end
    // syn == 0 with odd parity flips bit 0 itself, which the shift handles naturally.
    fix_code = s1_code ^ (CODE_W'(fix_single) << s1_syn);
    fix_pos  = fix_single ? {1'b0, s1_syn} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_o_valid  <= 1'b0;
      dec_o_data   <= '0;
      dec_o_single <= 1'b0;
      dec_o_double <= 1'b0;
      dec_o_pos    <= '0;
    end else if (s2_ready) begin
      dec_o_valid <= s1_valid;
      if (s1_valid) begin
        dec_o_data   <= extract(fix_code);
        dec_o_single <= fix_single;
        dec_o_double <= fix_double;
        dec_o_pos    <= fix_pos;
      end
    end
  end

  // ---------------------------------------------------------------- counters
  logic dec_fire;
  assign dec_fire = dec_o_valid && dec_o_ready;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (dec_fire) begin
      if (dec_o_single && (cnt_single != '1)) cnt_single <= cnt_single + 1'b1;
      if (dec_o_double && (cnt_double != '1)) cnt_double <= cnt_double + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed bench for hamming_secded_codec: DATA_W=4 vectors, DATA_W=8 streamed loopback,
// 2-bit counter saturation/clear, and reset with full pipelines.

module tb_hamming_secded_codec;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------ DATA_W=4 instance (u4)
  logic       enc4_i_valid, enc4_i_ready, enc4_o_valid, enc4_o_ready;
  logic [3:0] enc4_i_data;
  logic [7:0] enc4_o_code;
  logic       dec4_i_valid, dec4_i_ready, dec4_o_valid, dec4_o_ready;
  logic [7:0] dec4_i_code;
  logic [3:0] dec4_o_data;
  logic       dec4_o_single, dec4_o_double;
  logic [3:0] dec4_o_pos;
  logic       cnt4_clr;
  logic [15:0] cnt4_single, cnt4_double;

  hamming_secded_codec #(.DATA_W(4), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst),
    .enc_i_valid(enc4_i_valid), .enc_i_ready(enc4_i_ready), .enc_i_data(enc4_i_data),
    .enc_o_valid(enc4_o_valid), .enc_o_ready(enc4_o_ready), .enc_o_code(enc4_o_code),
    .dec_i_valid(dec4_i_valid), .dec_i_ready(dec4_i_ready), .dec_i_code(dec4_i_code),
    .dec_o_valid(dec4_o_valid), .dec_o_ready(dec4_o_ready), .dec_o_data(dec4_o_data),
    .dec_o_single(dec4_o_single), .dec_o_double(dec4_o_double), .dec_o_pos(dec4_o_pos),
    .cnt_clr(cnt4_clr), .cnt_single(cnt4_single), .cnt_double(cnt4_double)
  );

  // ------------------------------------------------ DATA_W=8 instance (u8), encoder looped into decoder
  logic        enc8_i_valid, enc8_i_ready, enc8_o_valid, enc8_o_ready;
  logic [7:0]  enc8_i_data;
  logic [12:0] enc8_o_code;
  logic        dec8_i_ready, dec8_o_valid, dec8_o_ready;
  logic [12:0] dec8_i_code;
  logic [7:0]  dec8_o_data;
  logic        dec8_o_single, dec8_o_double;
  logic [4:0]  dec8_o_pos;
  logic        cnt8_clr;
  logic [15:0] cnt8_single, cnt8_double;
  logic        link_en;
  int          flip_idx;

  assign enc8_o_ready = dec8_i_ready;
  assign dec8_i_code  = enc8_o_code ^ (link_en ? (13'(1) << flip_idx) : 13'(0));

  hamming_secded_codec #(.DATA_W(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst),
    .enc_i_valid(enc8_i_valid), .enc_i_ready(enc8_i_ready), .enc_i_data(enc8_i_data),
    .enc_o_valid(enc8_o_valid), .enc_o_ready(enc8_o_ready), .enc_o_code(enc8_o_code),
    .dec_i_valid(enc8_o_valid), .dec_i_ready(dec8_i_ready), .dec_i_code(dec8_i_code),
    .dec_o_valid(dec8_o_valid), .dec_o_ready(dec8_o_ready), .dec_o_data(dec8_o_data),
    .dec_o_single(dec8_o_single), .dec_o_double(dec8_o_double), .dec_o_pos(dec8_o_pos),
    .cnt_clr(cnt8_clr), .cnt_single(cnt8_single), .cnt_double(cnt8_double)
  );

  // ------------------------------------------------ DATA_W=4, CNT_W=2 instance (us)
  logic       encs_i_ready, encs_o_valid;
  logic [7:0] encs_o_code;
  logic       decs_i_valid, decs_i_ready, decs_o_valid, decs_o_ready;
  logic [7:0] decs_i_code;
  logic [3:0] decs_o_data;
  logic       decs_o_single, decs_o_double;
  logic [3:0] decs_o_pos;
  logic       cnts_clr;
  logic [1:0] cnts_single, cnts_double;

  hamming_secded_codec #(.DATA_W(4), .CNT_W(2)) us (
    .clk(clk), .rst(rst),
    .enc_i_valid(1'b0), .enc_i_ready(encs_i_ready), .enc_i_data(4'h0),
    .enc_o_valid(encs_o_valid), .enc_o_ready(1'b1), .enc_o_code(encs_o_code),
    .dec_i_valid(decs_i_valid), .dec_i_ready(decs_i_ready), .dec_i_code(decs_i_code),
    .dec_o_valid(decs_o_valid), .dec_o_ready(decs_o_ready), .dec_o_data(decs_o_data),
    .dec_o_single(decs_o_single), .dec_o_double(decs_o_double), .dec_o_pos(decs_o_pos),
    .cnt_clr(cnts_clr), .cnt_single(cnts_single), .cnt_double(cnts_double)
  );

  // One word through the u4 decoder with the output always ready.
  task automatic dec4(input string tag, input logic [7:0] code, input logic [3:0] data,
                      input logic single, input logic double, input logic [3:0] pos);
    dec4_i_valid = 1'b1;
    dec4_i_code  = code;
    dec4_o_ready = 1'b1;
    tick();
    dec4_i_valid = 1'b0;
    dec4_i_code  = 8'h00;
    tick();
    check({tag, "_valid"}, 64'(dec4_o_valid), 64'd1);
    check({tag, "_data"}, 64'(dec4_o_data), 64'(data));
    check({tag, "_flags"}, 64'({dec4_o_double, dec4_o_single}), 64'({double, single}));
    check({tag, "_pos"}, 64'(dec4_o_pos), 64'(pos));
    tick();
    check({tag, "_drain"}, 64'(dec4_o_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    enc4_i_valid = 1'b0; enc4_i_data = '0; enc4_o_ready = 1'b1;
    dec4_i_valid = 1'b0; dec4_i_code = '0; dec4_o_ready = 1'b1; cnt4_clr = 1'b0;
    enc8_i_valid = 1'b0; enc8_i_data = '0; dec8_o_ready = 1'b1; cnt8_clr = 1'b0;
    link_en = 1'b0; flip_idx = 0;
    decs_i_valid = 1'b0; decs_i_code = '0; decs_o_ready = 1'b1; cnts_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_enc_ready", 64'(enc4_i_ready), 64'd1);
    check("rst_dec_ready", 64'(dec4_i_ready), 64'd1);
    check("rst_valids", 64'({enc4_o_valid, dec4_o_valid}), 64'd0);
    check("rst_outs", 64'({dec4_o_data, dec4_o_single, dec4_o_double, dec4_o_pos}), 64'd0);
    check("rst_cnts", 64'({cnt4_single, cnt4_double}), 64'd0);

    // Encode 1011 -> AA; then stall output and check hold, back-to-back accept of 0001 -> 0F
    enc4_i_valid = 1'b1; enc4_i_data = 4'b1011; enc4_o_ready = 1'b0;
    tick();
    enc4_i_data = 4'b0001;
    check("enc_aa_valid", 64'(enc4_o_valid), 64'd1);
    check("enc_aa_code", 64'(enc4_o_code), 64'hAA);
    check("enc_stall_ready", 64'(enc4_i_ready), 64'd0);
    tick();
    check("enc_hold_code", 64'(enc4_o_code), 64'hAA);
    enc4_o_ready = 1'b1;
    tick();
    enc4_i_valid = 1'b0;
    check("enc_0f_code", 64'(enc4_o_code), 64'h0F);
    check("enc_0f_valid", 64'(enc4_o_valid), 64'd1);
    tick();
    check("enc_drain", 64'(enc4_o_valid), 64'd0);

    // Decode vectors
    dec4("dec_clean", 8'hAA, 4'b1011, 1'b0, 1'b0, 4'd0);
    check("cnt_after_clean", 64'({cnt4_single, cnt4_double}), 64'd0);
    dec4("dec_bit5", 8'h8A, 4'b1011, 1'b1, 1'b0, 4'd5);
    check("cnt_single_1", 64'(cnt4_single), 64'd1);
    dec4("dec_bit0", 8'hAB, 4'b1011, 1'b1, 1'b0, 4'd0);
    check("cnt_single_2", 64'(cnt4_single), 64'd2);
    dec4("dec_double", 8'h82, 4'b1000, 1'b0, 1'b1, 4'd0);
    check("cnt_double_1", 64'(cnt4_double), 64'd1);
    check("cnt_single_still2", 64'(cnt4_single), 64'd2);

    // Stalled output: held stable, stall cycles not counted
    dec4_o_ready = 1'b0;
    dec4_i_valid = 1'b1; dec4_i_code = 8'h8A;
    tick();
    dec4_i_valid = 1'b0;
    repeat (3) tick();
    check("stall_valid", 64'(dec4_o_valid), 64'd1);
    check("stall_pos", 64'(dec4_o_pos), 64'd5);
    check("stall_cnt", 64'(cnt4_single), 64'd2);
    dec4_o_ready = 1'b1;
    tick();
    check("stall_release_cnt", 64'(cnt4_single), 64'd3);
    check("stall_release_valid", 64'(dec4_o_valid), 64'd0);

    // CNT_W=2 saturation: five back-to-back single errors
    decs_i_valid = 1'b1; decs_i_code = 8'h8A;
    repeat (5) tick();
    decs_i_valid = 1'b0;
    repeat (4) tick();
    check("sat_cnt", 64'(cnts_single), 64'd3);
    check("sat_drain", 64'(decs_o_valid), 64'd0);
    // Clear coinciding with a single-error transfer wins
    decs_i_valid = 1'b1;
    tick();
    decs_i_valid = 1'b0;
    tick();
    check("clr_pre_valid", 64'(decs_o_valid), 64'd1);
    cnts_clr = 1'b1;
    tick();
    cnts_clr = 1'b0;
    check("clr_wins", 64'(cnts_single), 64'd0);
    decs_i_valid = 1'b1;
    tick();
    decs_i_valid = 1'b0;
    repeat (2) tick();
    check("clr_then_inc", 64'(cnts_single), 64'd1);

    // DATA_W=8 hand-computed codewords, no flips on the link
    enc8_i_valid = 1'b1; enc8_i_data = 8'h01;
    tick();
    enc8_i_data = 8'hFF;
    check("enc8_01", 64'(enc8_o_code), 64'h00F);
    tick();
    enc8_i_valid = 1'b0;
    check("enc8_ff", 64'(enc8_o_code), 64'h1EEE);
    tick();
    check("dec8_clean_01", 64'({dec8_o_valid, dec8_o_data, dec8_o_single}), 64'({1'b1, 8'h01, 1'b0}));
    repeat (3) tick();
    check("dec8_clean_cnt", 64'({cnt8_single, cnt8_double}), 64'd0);

    // Stream all 256 values through encode -> single flip -> decode, random output ready
    link_en  = 1'b1;
    flip_idx = $urandom_range(0, 12);
    fork
      begin : producer
        for (int v = 0; v < 256; v++) begin
          int waited;
          waited = 0;
          enc8_i_valid = 1'b1;
          enc8_i_data  = 8'(v);
          @(negedge clk);
          while (!enc8_i_ready && waited < 200) begin
            @(negedge clk);
            waited++;
          end
          @(posedge clk);
          #1;
        end
        enc8_i_valid = 1'b0;
      end
      begin : consumer
        int   rcv;
        int   cyc;
        logic link_xfer;
        int   pos_q[$];
        int   exp_pos;
        rcv = 0; cyc = 0; link_xfer = 1'b0;
        while (rcv < 256 && cyc < 4000) begin
          @(posedge clk);
          #1;
          if (link_xfer) flip_idx = $urandom_range(0, 12);
          dec8_o_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          link_xfer = enc8_o_valid && dec8_i_ready;
          if (link_xfer) pos_q.push_back(flip_idx);
          if (dec8_o_valid && dec8_o_ready) begin
            exp_pos = (pos_q.size() > 0) ? pos_q.pop_front() : -1;
            check("stream_data", 64'(dec8_o_data), 64'(rcv[7:0]));
            check("stream_flags", 64'({dec8_o_double, dec8_o_single}), 64'd1);
            check("stream_pos", 64'(dec8_o_pos), 64'(exp_pos));
            rcv++;
          end
          cyc++;
        end
        check("stream_count", 64'(rcv), 64'd256);
        tick();
        dec8_o_ready = 1'b1;
        repeat (4) tick();
        check("stream_extra", 64'(dec8_o_valid), 64'd0);
        check("stream_cnt_single", 64'(cnt8_single), 64'd256);
        check("stream_cnt_double", 64'(cnt8_double), 64'd0);
      end
    join

    // Reset with both decoder stages (and the encoder) full
    dec4_o_ready = 1'b0; enc4_o_ready = 1'b0;
    dec4_i_valid = 1'b1; dec4_i_code = 8'h8A;
    enc4_i_valid = 1'b1; enc4_i_data = 4'b1011;
    tick();
    enc4_i_valid = 1'b0;
    dec4_i_code  = 8'hAB;
    tick();
    dec4_i_valid = 1'b0;
    check("full_dec_valid", 64'(dec4_o_valid), 64'd1);
    check("full_dec_ready", 64'(dec4_i_ready), 64'd0);
    rst = 1'b1;
    tick();
    check("rst_mid_valids", 64'({dec4_o_valid, enc4_o_valid}), 64'd0);
    check("rst_mid_cnts", 64'({cnt4_single, cnt4_double}), 64'd0);
    check("rst_mid_outs", 64'({dec4_o_data, dec4_o_single, dec4_o_pos}), 64'd0);
    rst = 1'b0;
    dec4_o_ready = 1'b1; enc4_o_ready = 1'b1;
    check("rst_mid_ready", 64'({dec4_i_ready, enc4_i_ready}), 64'd3);
    begin
      logic seen;
      seen = 1'b0;
      repeat (5) begin
        tick();
        seen = seen | dec4_o_valid | enc4_o_valid;
      end
      check("rst_no_stale", 64'(seen), 64'd0);
    end
    check("rst_cnt_stay0", 64'(cnt4_single), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
